fetch_unit: RTL and testbench

//  Program-counter owner and instruction fetch sequencer of the multi-cycle CPU. Holds the architectural PC,

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_retire_counter.sv | 22 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared definitions: FSM state encodings,
// default reset PC and the npc alignment helper.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ   = 3'd0,
        FETCH_WAIT  = 3'd1,
        FETCH_ISSUE = 3'd2,
        FETCH_EXEC  = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned; any low-bit set is a fault.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_retire_counter.sv
// Committed-instruction counter: 32-bit, wraps modulo 2^32.
// Ports: clk, rst (async high), i_en (count), o_cnt (value).
module fetch_retire_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// PC owner and fetch sequencer: REQ -> WAIT -> ISSUE -> EXEC loop.
// Ports: imem req/rsp, decode valid/ready, npc commit, pc, fault, retire_cnt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        pc_update,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] retire_cnt
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fault;

    logic        w_commit;
    logic        w_npc_ok;
    logic        w_rsp_take;

    // A commit only counts while execute owns the instruction.
    assign w_commit   = (r_state == FETCH_EXEC) && pc_update;
    assign w_npc_ok   = is_aligned(npc);
    assign w_rsp_take = (r_state == FETCH_WAIT) && imem_rsp_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = FETCH_ISSUE;
                end
            end
            FETCH_ISSUE: begin
                if (inst_ready) begin
                    w_state_nxt = FETCH_EXEC;
                end
            end
            FETCH_EXEC: begin
                if (pc_update) begin
                    w_state_nxt = w_npc_ok ? FETCH_REQ : FETCH_FAULT;
                end
            end
            FETCH_FAULT: begin
                w_state_nxt = FETCH_FAULT;
            end
            default: begin
                // Unused encodings park in the terminal state.
                w_state_nxt = FETCH_FAULT;
            end
        endcase
    end

    // Output decode; request is masked while reset is held.
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        unique case (r_state)
            FETCH_REQ:   imem_req_valid = ~rst;
            FETCH_ISSUE: inst_valid     = 1'b1;
            default: begin
                imem_req_valid = 1'b0;
                inst_valid     = 1'b0;
            end
        endcase
    end

    // PC only moves on an aligned commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_commit && w_npc_ok) begin
            r_pc <= npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= 32'd0;
        end else if (w_rsp_take) begin
            r_inst <= imem_rsp_data;
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_commit && !w_npc_ok) begin
            r_fault <= 1'b1;
        end
    end

    fetch_retire_counter u_retire (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_commit),
        .o_cnt (retire_cnt)
    );

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign fault     = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver queues expected fetch
// addresses / instructions, a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = 32'd0;
    logic        pc_update = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] retire_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_inst[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .npc            (npc),
        .pc_update      (pc_update),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .fault          (fault),
        .retire_cnt     (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (q_addr.size() == 0) begin
                chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", imem_addr, q_addr.pop_front());
            end
        end
        if (!rst && inst_valid && inst_ready) begin
            if (q_inst.size() == 0) begin
                chk("unexpected_inst", inst, 32'hFFFF_FFFF);
            end else begin
                chk("inst", inst, q_inst.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from REQ to EXEC; optional noise pulses on pc_update.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input logic noise);
        q_addr.push_back(addr);
        q_inst.push_back(data);
        pc_update      = noise;
        npc            = 32'hDEAD_0000;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        step();
        inst_ready     = 1'b0;
        pc_update      = 1'b0;
    endtask

    task automatic commit(input logic [31:0] target);
        npc       = target;
        pc_update = 1'b1;
        step();
        pc_update = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Memory back-pressure: request held, address stable.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_addr, 32'd0);
            @(posedge clk);
            #1;
        end

        // First fetch with pc_update noise, then commit to 0x100.
        fetch(32'h0000_0000, 32'h0000_0013, 1'b1);
        chk("exec_inst", inst, 32'h0000_0013);
        chk("noise_pc", pc, 32'd0);
        chk("noise_retire", retire_cnt, 32'd0);
        commit(32'h0000_0100);
        chk("commit_pc", pc, 32'h0000_0100);
        chk("commit_retire", retire_cnt, 32'd1);

        fetch(32'h0000_0100, 32'h0050_0093, 1'b1);
        chk("noise2_pc", pc, 32'h0000_0100);
        chk("noise2_retire", retire_cnt, 32'd1);
        commit(32'h0000_0200);
        fetch(32'h0000_0200, 32'h0010_8113, 1'b0);

        // Counter wrap through a preloaded all-ones value.
        force dut.u_retire.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire.r_cnt;
        #1;
        chk("preload", retire_cnt, 32'hFFFF_FFFF);
        commit(32'h0000_0300);
        chk("wrap_retire", retire_cnt, 32'd0);
        chk("wrap_pc", pc, 32'h0000_0300);

        // Reset while waiting on memory.
        q_addr.push_back(32'h0000_0300);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req_valid}, 32'd0);
        chk("mid_rst_retire", retire_cnt, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // Stale response while in REQ must be ignored.
        step();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stale_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("stale_inst", inst, 32'd0);
        @(posedge clk);
        #1;

        // Restart from RESET_PC, then misaligned commit.
        fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
        commit(32'h0000_0040);
        fetch(32'h0000_0040, 32'h0020_0113, 1'b0);
        commit(32'h0000_0102);
        chk("fault", {31'd0, fault}, 32'd1);
        chk("fault_pc", pc, 32'h0000_0040);
        chk("fault_retire", retire_cnt, 32'd2);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("fault_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("fault_sticky", {31'd0, fault}, 32'd1);
            @(posedge clk);
            #1;
        end
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;

        chk("addr_q_empty", q_addr.size(), 32'd0);
        chk("inst_q_empty", q_inst.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
